// File: rtl/mc_sequencer_if.sv
// rtl/mc_sequencer_if.sv - sequencer <-> datapath control bundle; MC_PERF_CNT_EN adds perf counter outputs
interface mc_sequencer_if;
    logic [6:0]  opcode;
    logic        mem_ready;
    logic        pc_write;
    logic        ir_write;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic        pc_write_cond;
    logic [1:0]  alu_operation;
    logic        instr_done;
    logic        mem_err;
    logic        illegal_op;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;
`endif

    modport master (
        input  opcode, mem_ready,
        output pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg,
               alu_src, pc_write_cond, alu_operation, instr_done, mem_err, illegal_op
`ifdef MC_PERF_CNT_EN
        , output cycle_cnt, instret_cnt
`endif
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg,
               alu_src, pc_write_cond, alu_operation, instr_done, mem_err, illegal_op
`ifdef MC_PERF_CNT_EN
        , input cycle_cnt, instret_cnt
`endif
    );
endinterface

// File: rtl/mc_sequencer.sv
// rtl/mc_sequencer.sv - multicycle FETCH/DECODE/EXEC/MEM/WB control sequencer with memory wait timeout
// Optional MC_PERF_CNT_EN adds 32-bit cycle_cnt and instret_cnt outputs.
module mc_sequencer #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    mc_sequencer_if.master bus
);
    localparam int WW = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_WAIT_MAX - 1);
    localparam logic [WW-1:0] WAIT_SAT  = WW'(MEM_WAIT_MAX);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [6:0]      r_opcode;
    logic [WW-1:0]   r_wait;
    logic [WW-1:0]   w_wait_next;
    logic            w_wait_hit;

    logic            w_pc_write, w_ir_write, w_mem_read, w_mem_write;
    logic            w_reg_write, w_mem_to_reg, w_alu_src, w_pc_write_cond;
    logic [1:0]      w_alu_op;
    logic            w_instr_done, w_mem_err, w_illegal_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_FETCH;
            r_opcode <= '0;
            r_wait   <= '0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait_next;
            if (r_state == S_DECODE) begin
                r_opcode <= bus.opcode;
            end
        end
    end

    always_comb begin
        w_next          = r_state;
        w_wait_next     = r_wait;
        w_pc_write      = 1'b0;
        w_ir_write      = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_reg_write     = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_alu_src       = 1'b0;
        w_pc_write_cond = 1'b0;
        w_alu_op        = 2'b00;
        w_instr_done    = 1'b0;
        w_mem_err       = 1'b0;
        w_illegal_op    = 1'b0;
        // r_wait counts earlier low cycles, so this is the MEM_WAIT_MAX-th consecutive low cycle
        w_wait_hit      = !bus.mem_ready && (r_wait == WAIT_LAST);

        case (r_state)
            S_FETCH: begin
                w_mem_read = 1'b1;
                if (bus.mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end else if (w_wait_hit) begin
                    w_mem_err = 1'b1;
                    w_next    = S_FETCH;
                end
            end
            S_DECODE: begin
                if (bus.opcode == OP_R || bus.opcode == OP_LD ||
                    bus.opcode == OP_SD || bus.opcode == OP_BEQ) begin
                    w_next = S_EXEC;
                end else begin
                    w_illegal_op = 1'b1;
                    w_next       = S_FETCH;
                end
            end
            S_EXEC: begin
                case (r_opcode)
                    OP_R: begin
                        w_alu_op = 2'b10;
                        w_next   = S_WB;
                    end
                    OP_LD, OP_SD: begin
                        w_alu_src = 1'b1;
                        w_next    = S_MEM;
                    end
                    OP_BEQ: begin
                        w_alu_op        = 2'b01;
                        w_pc_write_cond = 1'b1;
                        w_instr_done    = 1'b1;
                        w_next          = S_FETCH;
                    end
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                w_mem_read  = (r_opcode == OP_LD);
                w_mem_write = (r_opcode == OP_SD);
                if (bus.mem_ready) begin
                    if (r_opcode == OP_LD) begin
                        w_next = S_WB;
                    end else begin
                        w_instr_done = 1'b1;
                        w_next       = S_FETCH;
                    end
                end else if (w_wait_hit) begin
                    w_mem_write = 1'b0;
                    w_mem_err   = 1'b1;
                    w_next      = S_FETCH;
                end
            end
            S_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = (r_opcode == OP_LD);
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase

        // A timeout re-enters FETCH through a self-loop, which still counts as a fresh entry
        if ((w_next == S_FETCH || w_next == S_MEM) && (w_next != r_state || w_mem_err)) begin
            w_wait_next = '0;
        end else if ((r_state == S_FETCH || r_state == S_MEM) && !bus.mem_ready &&
                     r_wait != WAIT_SAT) begin
            w_wait_next = r_wait + 1'b1;
        end
    end

    assign bus.pc_write      = rst_n & w_pc_write;
    assign bus.ir_write      = rst_n & w_ir_write;
    assign bus.mem_read      = rst_n & w_mem_read;
    assign bus.mem_write     = rst_n & w_mem_write;
    assign bus.reg_write     = rst_n & w_reg_write;
    assign bus.mem_to_reg    = rst_n & w_mem_to_reg;
    assign bus.alu_src       = rst_n & w_alu_src;
    assign bus.pc_write_cond = rst_n & w_pc_write_cond;
    assign bus.alu_operation = rst_n ? w_alu_op : 2'b00;
    assign bus.instr_done    = rst_n & w_instr_done;
    assign bus.mem_err       = rst_n & w_mem_err;
    assign bus.illegal_op    = rst_n & w_illegal_op;

`ifdef MC_PERF_CNT_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instret_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (w_instr_done) begin
                r_instret_cnt <= r_instret_cnt + 32'd1;
            end
        end
    end

    assign bus.cycle_cnt   = r_cycle_cnt;
    assign bus.instret_cnt = r_instret_cnt;
`endif
endmodule

// File: tb/tb_mc_sequencer.sv
// tb/tb_mc_sequencer.sv - self-checking bench for mc_sequencer (MC_PERF_CNT_EN adds counter checks)
`timescale 1ns/1ps
module tb_mc_sequencer;
    localparam int MAXW = 15;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    // Output vector {pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg,
    // alu_src, pc_write_cond, alu_operation[1:0], instr_done, mem_err, illegal_op}
    localparam logic [12:0] PCW  = 13'h1000;
    localparam logic [12:0] IRW  = 13'h0800;
    localparam logic [12:0] MRD  = 13'h0400;
    localparam logic [12:0] MWR  = 13'h0200;
    localparam logic [12:0] RW   = 13'h0100;
    localparam logic [12:0] M2R  = 13'h0080;
    localparam logic [12:0] ASRC = 13'h0040;
    localparam logic [12:0] PWC  = 13'h0020;
    localparam logic [12:0] AFN  = 13'h0010;
    localparam logic [12:0] ABR  = 13'h0008;
    localparam logic [12:0] DONE = 13'h0004;
    localparam logic [12:0] ERR  = 13'h0002;
    localparam logic [12:0] ILL  = 13'h0001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mc_sequencer_if bus();
    mc_sequencer #(.MEM_WAIT_MAX(MAXW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [12:0] w_out;
    assign w_out = {bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write, bus.reg_write,
                    bus.mem_to_reg, bus.alu_src, bus.pc_write_cond, bus.alu_operation,
                    bus.instr_done, bus.mem_err, bus.illegal_op};

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge: drive, settle, compare, advance to the next negedge.
    task automatic step(input logic [6:0] op, input logic rdy, input logic [12:0] exp,
                        input string name);
        bus.opcode    = op;
        bus.mem_ready = rdy;
        #1;
        chk(name, {19'd0, w_out}, {19'd0, exp});
        @(negedge clk);
    endtask

    function automatic logic [6:0] junk();
        return 7'($urandom);
    endfunction

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    // Reference: one instruction as a sequence of phases; fw/mw = low cycles before ready
    // in FETCH / MEM. An access stuck low for MAXW cycles is abandoned on that cycle.
    task automatic run_model(input logic [6:0] op, input int fw, input int mw);
        bit legal;
        bit is_ld;
        legal = (op == OP_R) || (op == OP_LD) || (op == OP_SD) || (op == OP_BEQ);
        is_ld = (op == OP_LD);
        for (int k = 1; ; k++) begin
            if (k > fw) begin
                step(junk(), 1'b1, MRD | IRW | PCW, "fetch");
                break;
            end else if (k == MAXW) begin
                step(junk(), 1'b0, MRD | ERR, "fetch_timeout");
                return;
            end else begin
                step(junk(), 1'b0, MRD, "fetch_wait");
            end
        end
        step(op, rbit(), legal ? 13'h0 : ILL, "decode");
        if (!legal) return;
        if (op == OP_R) begin
            step(junk(), rbit(), AFN, "exec_r");
            step(junk(), rbit(), RW | DONE, "wb_r");
            return;
        end
        if (op == OP_BEQ) begin
            step(junk(), rbit(), ABR | PWC | DONE, "exec_beq");
            return;
        end
        step(junk(), rbit(), ASRC, "exec_mem");
        for (int k = 1; ; k++) begin
            if (k > mw) begin
                if (is_ld) begin
                    step(junk(), 1'b1, MRD, "mem_ld");
                    break;
                end
                step(junk(), 1'b1, MWR | DONE, "mem_sd");
                return;
            end else if (k == MAXW) begin
                step(junk(), 1'b0, (is_ld ? MRD : 13'h0) | ERR, "mem_timeout");
                return;
            end else begin
                step(junk(), 1'b0, is_ld ? MRD : MWR, "mem_wait");
            end
        end
        step(junk(), rbit(), RW | M2R | DONE, "wb_ld");
    endtask

    typedef struct {
        string      name;
        logic [6:0] op;
        int         lo_start;
        int         lo_len;
        int         exp_cyc;
        int         exp_kind;   // 0 instr_done, 1 mem_err, 2 illegal_op
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{"r_zero",        OP_R,    0, 0,  4,  0};
        tbl[1]  = '{"ld_zero",       OP_LD,   0, 0,  5,  0};
        tbl[2]  = '{"sd_zero",       OP_SD,   0, 0,  4,  0};
        tbl[3]  = '{"beq_zero",      OP_BEQ,  0, 0,  3,  0};
        tbl[4]  = '{"illegal_7f",    OP_BAD,  0, 0,  2,  2};
        tbl[5]  = '{"ld_mem_wait3",  OP_LD,   4, 3,  8,  0};
        tbl[6]  = '{"sd_mem_tmo",    OP_SD,   4, 15, 18, 1};
        tbl[7]  = '{"fetch_tmo",     OP_R,    1, 15, 15, 1};
        tbl[8]  = '{"ld_ready_at15", OP_LD,   4, 14, 19, 0};
        tbl[9]  = '{"r_fetch_wait2", OP_R,    1, 2,  6,  0};
        tbl[10] = '{"illegal_00",    7'h00,   0, 0,  2,  2};
        tbl[11] = '{"beq_fetch14",   OP_BEQ,  1, 14, 17, 0};

        bus.opcode    = '0;
        bus.mem_ready = 1'b0;
        rst_n         = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_outputs", {19'd0, w_out}, 32'd0);
        chk("reset_mem_read", {31'd0, bus.mem_read}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) run_model(OP_R, 0, 0);
`ifdef MC_PERF_CNT_EN
        chk("perf_cycle_cnt", bus.cycle_cnt, 32'd12);
        chk("perf_instret_cnt", bus.instret_cnt, 32'd3);
`endif

        foreach (tbl[i]) begin
            int got_c;
            int got_k;
            got_c = 0;
            got_k = -1;
            for (int c = 1; c <= 40 && got_k < 0; c++) begin
                bus.opcode    = tbl[i].op;
                bus.mem_ready = !(c >= tbl[i].lo_start && c < tbl[i].lo_start + tbl[i].lo_len);
                #1;
                if (bus.instr_done)      got_k = 0;
                else if (bus.mem_err)    got_k = 1;
                else if (bus.illegal_op) got_k = 2;
                if (got_k >= 0) got_c = c;
                @(negedge clk);
            end
            chk({tbl[i].name, "_cycles"}, got_c, tbl[i].exp_cyc);
            chk({tbl[i].name, "_kind"}, got_k, tbl[i].exp_kind);
        end

        run_model(OP_R, 0, 0);
        run_model(OP_LD, 0, 3);
        run_model(OP_BEQ, 0, 0);
        run_model(OP_SD, 0, 20);
        run_model(OP_LD, 0, 14);
        run_model(OP_LD, 0, 15);
        run_model(OP_R, 16, 0);
        run_model(OP_BAD, 0, 0);

        // Asynchronous reset in the EXEC cycle of a load, then a clean restart
        step(junk(), 1'b1, MRD | IRW | PCW, "rst_seq_fetch");
        step(OP_LD, 1'b1, 13'h0, "rst_seq_decode");
        bus.opcode    = junk();
        bus.mem_ready = 1'b1;
        #1;
        chk("rst_seq_exec", {19'd0, w_out}, {19'd0, ASRC});
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {19'd0, w_out}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_model(OP_LD, 0, 0);

        for (int n = 0; n < 300; n++) begin
            logic [6:0] op;
            int sel;
            int fw;
            int mw;
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1:    op = OP_R;
                2, 3:    op = OP_LD;
                4, 5:    op = OP_SD;
                6, 7:    op = OP_BEQ;
                default: op = junk();
            endcase
            fw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 17) : 0;
            mw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 17) : 0;
            run_model(op, fw, mw);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mc_sequencer.md
MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 SHALL have parameter MEM_WAIT_MAX, default 15: the maximum number of consecutive cycles with mem_ready low tolerated in FETCH or MEM.
REQ-002 SHALL have clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have opcode, input, 7: opcode field of the instruction register.
REQ-005 SHALL have mem_ready, input, 1: memory access complete in the current cycle.
REQ-006 SHALL have pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg, alu_src, pc_write_cond, output, 1 each: datapath strobes.
REQ-007 SHALL have alu_operation, output, 2: ALU class code for alu_control (00 add, 01 branch compare, 10 funct-decoded).
REQ-008 SHALL have instr_done, mem_err, illegal_op, output, 1 each: one-cycle status pulses.

Function
REQ-009 SHALL implement the states FETCH, DECODE, EXEC, MEM, WB, encoded in a 3-bit state register.
REQ-010 SHALL produce all outputs combinationally from the state register, the latched opcode and mem_ready (Moore outputs, except the mem_ready qualification).
REQ-011 In FETCH: mem_read=1 and alu_operation=00; on mem_ready=1, ir_write=1, pc_write=1 and next state = DECODE; otherwise remain in FETCH.
REQ-012 In DECODE: latch opcode into an internal register; 0110011, 0000011, 0100011 and 1100011 go to EXEC; any other opcode pulses illegal_op and goes to FETCH.
REQ-013 In EXEC with R-type (0110011): alu_operation=10, alu_src=0; next state = WB.
REQ-014 In EXEC with ld (0000011) or sd (0100011): alu_operation=00, alu_src=1; next state = MEM.
REQ-015 In EXEC with beq (1100011): alu_operation=01, alu_src=0, pc_write_cond=1, instr_done=1; next state = FETCH.
REQ-016 In MEM: mem_read=1 for ld, mem_write=1 for sd; on mem_ready, ld goes to WB, while sd pulses instr_done and goes to FETCH.
REQ-017 In WB: reg_write=1, mem_to_reg=1 for ld and 0 for R-type, instr_done=1; next state = FETCH.
REQ-018 With zero-wait memory, latency SHALL be: R-type 4 cycles, ld 5, sd 4, beq 3, and illegal opcode 2.
REQ-019 A wait counter SHALL clear on entry to FETCH or MEM, increment each cycle spent there with mem_ready=0, and saturate.
REQ-020 When the wait counter equals MEM_WAIT_MAX and mem_ready=0: pulse mem_err, suppress all write strobes, and go to FETCH, abandoning the instruction.
REQ-021 If mem_ready=1 in the same cycle the wait counter reaches MEM_WAIT_MAX, the access SHALL complete normally with no mem_err.
REQ-022 Outputs not named for a state SHALL be 0 in that state.

Reset
REQ-023 rst_n low SHALL immediately force state=FETCH, wait counter=0 and latched opcode=0, regardless of clk.
REQ-024 While rst_n is low, every output except mem_read SHALL be 0; mem_read SHALL also be forced to 0 during reset.
REQ-025 Reset asserted mid-instruction SHALL abandon the instruction with no instr_done; the first access after release is a FETCH.

Configuration
REQ-026 Macro MC_PERF_CNT_EN, when defined, SHALL add the 32-bit outputs cycle_cnt (increments every cycle out of reset) and instret_cnt (increments on instr_done); both reset to 0 and wrap modulo 2^32.
REQ-027 Without MC_PERF_CNT_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-028 mem_ready tied to 1, opcode=0110011 -> states FETCH,DECODE,EXEC,WB; alu_operation=10 in EXEC; reg_write=1 and instr_done=1 in cycle 4.
REQ-029 opcode=0000011, mem_ready low for 3 MEM cycles -> mem_read held for 4 MEM cycles; WB has mem_to_reg=1; total 8 cycles; no mem_err.
REQ-030 opcode=1100011 -> pc_write_cond=1 with alu_operation=01 in cycle 3, followed by FETCH in cycle 4.
REQ-031 mem_ready=0 for 15 cycles in MEM for sd -> mem_err pulses on cycle 15 with mem_write=0 that cycle; next state FETCH; no instr_done.
REQ-032 opcode=1111111 -> illegal_op pulses in DECODE and FETCH follows; rst_n pulsed low during EXEC of ld -> outputs 0 asynchronously, then FETCH on release.
REQ-033 With MC_PERF_CNT_EN: 3 back-to-back R-type instructions at zero wait -> instret_cnt=3 and cycle_cnt=12.
